// File: rtl/vp_pkg.sv
// ---------------------------------------------------------------------------
// vp_pkg
// Shared definitions for the vector-processor instruction path.
//   IW            : instruction width (13 bits)
//   vp_opcode_t   : opcode encoding carried in bits [12:11]
//   *_MSB/*_LSB   : field bit positions (opcode, register, address)
//   seq_state_t   : sequencer FSM states
//   vp_get_opcode : helper to pull the opcode field out of an instruction
// ---------------------------------------------------------------------------
package vp_pkg;

    localparam int IW = 13;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_ADD   = 2'b10,
        OP_MUL   = 2'b11
    } vp_opcode_t;

    localparam int OPC_MSB  = 12;
    localparam int OPC_LSB  = 11;
    localparam int REG_MSB  = 10;
    localparam int REG_LSB  = 9;
    localparam int ADDR_MSB = 8;
    localparam int ADDR_LSB = 0;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'b00,
        SEQ_RUN  = 2'b01,
        SEQ_DONE = 2'b10
    } seq_state_t;

    function automatic vp_opcode_t vp_get_opcode(input logic [IW-1:0] instr);
        return vp_opcode_t'(instr[OPC_MSB:OPC_LSB]);
    endfunction

endpackage

// File: rtl/vp_instr_mem.sv
// ---------------------------------------------------------------------------
// vp_instr_mem
// DEPTH x IW program store: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset so a program survives a
// sequencer reset.
//   clk   : clock
//   we    : write strobe
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
// ---------------------------------------------------------------------------
module vp_instr_mem #(
    parameter int DEPTH = 16,
    parameter int IW    = 13,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/vp_instr_sequencer.sv
// ---------------------------------------------------------------------------
// vp_instr_sequencer
// Holds a host-written program and issues it in order to the vector core,
// one instruction per valid/ready handshake, under start/busy/done control.
//
// Optional feature macro: VP_SEQ_LOOP_EN
//   When defined, adds input loop_cnt[7:0] (sampled on start); the program
//   runs loop_cnt+1 passes back-to-back with a single done pulse at the end.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   prog_we/addr/data : program write port (honoured only in IDLE)
//   prog_len     : instruction count, sampled on start, clamped to DEPTH
//   start        : begin a run (honoured only in IDLE)
//   instruction  : registered instruction to the core (0 when not valid)
//   instr_valid  : instruction qualifier
//   instr_ready  : core acceptance
//   busy         : high while running
//   done         : one-cycle pulse after the final handshake
//   pc           : index of the instruction currently presented
// ---------------------------------------------------------------------------
module vp_instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int IW    = vp_pkg::IW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
`ifdef VP_SEQ_LOOP_EN
    input  logic [7:0]    loop_cnt,
`endif
    output logic [IW-1:0] instruction,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc
);

    import vp_pkg::*;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    seq_state_t    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          valid_q, valid_d;
`ifdef VP_SEQ_LOOP_EN
    logic [7:0]    pass_q, pass_d;
`endif

    logic          mem_we;
    logic [AW-1:0] rd_addr;
    logic [IW-1:0] rd_data;
    logic [IW-1:0] first_instr;
    logic [AW:0]   len_clamped;
    logic          handshake;
    logic          last_entry;
    logic          wrap;

    assign mem_we      = prog_we && (state_q == SEQ_IDLE);
    assign handshake   = valid_q && instr_ready;
    assign last_entry  = ({1'b0, pc_q} == (len_q - 1'b1));
    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

    // One read port serves both "next entry" and "restart at 0": on the last
    // entry the address is forced to 0, which is exactly what a loop wrap needs.
    assign rd_addr = ((state_q == SEQ_RUN) && !last_entry) ? (pc_q + 1'b1) : '0;

    // A write to entry 0 in the start cycle must be visible to the run, but
    // the asynchronous read still shows the old word, so bypass it.
    assign first_instr = (mem_we && (prog_addr == '0)) ? prog_data : rd_data;

`ifdef VP_SEQ_LOOP_EN
    assign wrap = (pass_q != 8'd0);
`else
    assign wrap = 1'b0;
`endif

    vp_instr_mem #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        instr_d = instr_q;
        valid_d = valid_q;
`ifdef VP_SEQ_LOOP_EN
        pass_d  = pass_q;
`endif
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    len_d = len_clamped;
                    pc_d  = '0;
`ifdef VP_SEQ_LOOP_EN
                    pass_d = loop_cnt;
`endif
                    if (len_clamped == '0) begin
                        state_d = SEQ_DONE;
                    end else begin
                        state_d = SEQ_RUN;
                        valid_d = 1'b1;
                        instr_d = first_instr;
                    end
                end
            end
            SEQ_RUN: begin
                if (handshake) begin
                    if (last_entry) begin
                        if (wrap) begin
                            pc_d    = '0;
                            instr_d = rd_data;
`ifdef VP_SEQ_LOOP_EN
                            pass_d  = pass_q - 8'd1;
`endif
                        end else begin
                            state_d = SEQ_DONE;
                            valid_d = 1'b0;
                            instr_d = '0;
                        end
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        instr_d = rd_data;
                    end
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
                valid_d = 1'b0;
                instr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEQ_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
`ifdef VP_SEQ_LOOP_EN
            pass_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef VP_SEQ_LOOP_EN
            pass_q  <= pass_d;
`endif
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = (state_q == SEQ_RUN);
    assign done        = (state_q == SEQ_DONE);

endmodule

// File: tb/tb_vp_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vp_instr_sequencer
// Self-checking bench for vp_instr_sequencer. A shadow copy of the program
// memory plus an expected-issue queue (program prefix repeated per pass)
// describes what the core should see; each presented cycle is compared.
// ---------------------------------------------------------------------------
module tb_vp_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int IW    = 13;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic [AW:0]   prog_len;
    logic          start;
`ifdef VP_SEQ_LOOP_EN
    logic [7:0]    loop_cnt;
`endif
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic          instr_ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;

    int total = 0;
    int bad   = 0;

    logic [IW-1:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    vp_instr_sequencer #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .AW    (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .start       (start),
`ifdef VP_SEQ_LOOP_EN
        .loop_cnt    (loop_cnt),
`endif
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .busy        (busy),
        .done        (done),
        .pc          (pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic wr(input int a, input logic [IW-1:0] d);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        @(posedge clk); #1;
        prog_we   = 1'b0;
        model_mem[a] = d;
        $display("write mem[%0d]=%h", a, d);
    endtask

    // mode 0: ready always high; 1: random ready plus ignored writes/starts;
    // 2: ready low for 3 cycles on the 2nd entry, with an ignored write of
    //    13'h1000 to entry 0 and start held high while running.
    task automatic run(input int len, input int mode, input int lc,
                       input bit wr0, input logic [IW-1:0] wr0_data);
        int n, passes, idx, stall_left, stalls, vcount, budget;
        logic [IW-1:0] exp_q[$];
        int            exp_pc[$];
        bit            rdy;
        n = (len > DEPTH) ? DEPTH : len;
        start    = 1'b1;
        prog_len = (AW+1)'(len);
`ifdef VP_SEQ_LOOP_EN
        loop_cnt = 8'(lc);
        passes   = lc + 1;
`else
        passes   = 1;
`endif
        if (wr0) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = wr0_data;
            model_mem[0] = wr0_data;
        end
        for (int p = 0; p < passes; p++)
            for (int k = 0; k < n; k++) begin
                exp_q.push_back(model_mem[k]);
                exp_pc.push_back(k);
            end
        @(posedge clk); #1;
        start   = 1'b0;
        prog_we = 1'b0;
        idx = 0; stall_left = 3; stalls = 0; vcount = 0; budget = 0;
        while (idx < exp_q.size()) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    rdy = !(idx == 1 && stall_left > 0);
                    if (!rdy) stall_left--;
                end
            endcase
            instr_ready = rdy;
            if (mode == 1) begin
                prog_we   = 1'($urandom_range(0, 1));
                prog_addr = AW'($urandom_range(0, DEPTH - 1));
                prog_data = IW'($urandom);
                start     = 1'($urandom_range(0, 1));
                prog_len  = (AW+1)'($urandom_range(0, DEPTH + 1));
            end else if (mode == 2) begin
                prog_we   = 1'b1;
                prog_addr = '0;
                prog_data = 13'h1000;
                start     = 1'b1;
            end
            @(negedge clk);
            chk("valid",    32'(instr_valid), 32'd1);
            chk("instr",    32'(instruction), 32'(exp_q[idx]));
            chk("pc",       32'(pc),          32'(exp_pc[idx]));
            chk("busy",     32'(busy),        32'd1);
            chk("done_run", 32'(done),        32'd0);
            $display("issue len=%0d idx=%0d pc=%0d instr=%h ready=%0b", len, idx, pc, instruction, rdy);
            if (instr_valid) vcount++;
            if (rdy) idx++; else stalls++;
            @(posedge clk); #1;
            prog_we = 1'b0;
            start   = 1'b0;
            budget++;
            if (budget > 2000) begin
                chk("cycle_budget", 32'd0, 32'd1);
                break;
            end
        end
        // Done cycle; a start here must be ignored.
        instr_ready = 1'($urandom_range(0, 1));
        start       = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("done_pulse",  32'(done),        32'd1);
        chk("done_valid",  32'(instr_valid), 32'd0);
        chk("done_instr",  32'(instruction), 32'd0);
        chk("done_busy",   32'(busy),        32'd0);
        chk("valid_count", 32'(vcount),      32'(exp_q.size() + stalls));
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("post_done",  32'(done),        32'd0);
        chk("post_busy",  32'(busy),        32'd0);
        chk("post_valid", 32'(instr_valid), 32'd0);
        $display("run len=%0d mode=%0d passes=%0d issued=%0d stalls=%0d done", len, mode, passes, vcount, stalls);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_run();
        start       = 1'b1;
        prog_len    = (AW+1)'(4);
        instr_ready = 1'b1;
`ifdef VP_SEQ_LOOP_EN
        loop_cnt    = 8'd0;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_pre_instr", 32'(instruction), 32'(model_mem[k]));
            chk("rst_pre_pc",    32'(pc),          32'(k));
            if (k < 2) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_pc",    32'(pc),          32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_no_done", 32'(done), 32'd0);
        $display("reset mid-run at pc=2");
        @(posedge clk); #1;
    endtask

    initial begin
        reset       = 1'b1;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        prog_len    = '0;
        start       = 1'b0;
        instr_ready = 1'b1;
`ifdef VP_SEQ_LOOP_EN
        loop_cnt    = 8'd0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_instr", 32'(instruction), 32'd0);
        chk("reset_busy",  32'(busy),        32'd0);
        chk("reset_done",  32'(done),        32'd0);
        chk("reset_pc",    32'(pc),          32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) wr(i, IW'($urandom));
        wr(0, 13'h0001);
        wr(1, 13'h0200);
        wr(2, 13'h0511);
        wr(3, 13'h0621);

        run(4, 0, 0, 1'b0, '0);          // straight run
        run(4, 2, 0, 1'b0, '0);          // 3-cycle stall on entry 1, busy writes/starts
        run(4, 0, 0, 1'b0, '0);          // entry 0 must still be 13'h0001
        run(0, 0, 0, 1'b0, '0);          // empty program
        run(DEPTH + 1, 0, 0, 1'b0, '0);  // clamp to DEPTH
        reset_mid_run();
        run(4, 0, 0, 1'b0, '0);          // memory survived reset
        run(3, 0, 0, 1'b1, 13'h0abc);    // write + start in the same cycle
        run(2, 0, 2, 1'b0, '0);          // A,B x3 when looping is built in

        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 1) == 1)
                wr($urandom_range(0, DEPTH - 1), IW'($urandom));
            run($urandom_range(0, DEPTH + 1), 1, $urandom_range(0, 3),
                1'($urandom_range(0, 1)), IW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vp_instr_sequencer.md
# vp_instr_sequencer

Instruction sequencer directly upstream of the vector processor core. It holds a small program of 13-bit vector instructions (load/store/add/mul) written by the host, then issues them in order, one per accepted handshake, onto the core's `instruction` input. It replaces hand-driven instruction streams with a start/busy/done controlled program run.

## Interface
Parameters:
- `DEPTH`, 16: program memory entries; power of two, at least 2.
- `IW`, 13: instruction width, with fields `[12:11]` opcode, `[10:9]` register, `[8:0]` address.
- `AW`, `$clog2(DEPTH)`: program address width (derived).

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-high.
- `prog_we`  in  1: program write strobe.
- `prog_addr`  in  AW: program write address.
- `prog_data`  in  IW: program write data.
- `prog_len`  in  AW+1: number of instructions to run; sampled on `start`.
- `start`  in  1: begin a run; honoured only in IDLE.
- `instruction`  out  IW: instruction to the core.
- `instr_valid`  out  1: `instruction` is meaningful; the core executes only while this is high.
- `instr_ready`  in  1: core accepts (tie high for the current core).
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse at the end of a run.
- `pc`  out  AW: index of the instruction currently presented.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `prog_we` writes `prog_data` to `mem[prog_addr]`.
  - On `start`: latch `len = min(prog_len, DEPTH)`.
  - `len==0` -> DONE.
  - Otherwise -> RUN, with `pc=0`, `instruction=mem[0]`, `instr_valid=1`.
- RUN: on each handshake (`instr_valid & instr_ready`):
  - If `pc==len-1`: -> DONE, `instr_valid=0`.
  - Otherwise: `pc+1`, `instruction=mem[pc+1]`.
- RUN, no handshake: `instruction`, `instr_valid` and `pc` are held stable.
- DONE: `done=1` for exactly one cycle, then -> IDLE.
- While not IDLE:
  - `prog_we` is ignored; the memory is unchanged.
  - `start` is ignored, including `start` asserted in the same cycle the FSM enters IDLE from DONE. A new start is accepted only from the next cycle onward.
- `prog_we` and `start` in the same IDLE cycle: the write completes first, so the run sees the new contents.
- `instruction` is held at 0 whenever `instr_valid=0`. The core must qualify execution with `instr_valid`, because 13'h0 decodes as LOAD.
- `pc` never wraps within a single pass. Its maximum value is `len-1`.

## Timing
- Reset values: state IDLE, `instruction=0`, `instr_valid=0`, `busy=0`, `done=0`, `pc=0`, `len=0`.
- Program memory is not reset; its contents survive reset.
- Reset mid-run: the next cycle is IDLE with all outputs at their reset values. No `done` pulse is produced.
- Latency:
  - `start` to first `instr_valid`: 1 cycle.
  - With `instr_ready` held high: one instruction per cycle and no bubbles, so a full run takes `len` cycles of valid.
  - Last handshake to `done`: 1 cycle.
- Memory reads are asynchronous; `instruction` is a registered output.

## Configuration
- `VP_SEQ_LOOP_EN`: when defined:
  - Adds input `loop_cnt [7:0]`, sampled on `start`.
  - The program runs `loop_cnt+1` passes.
  - On the last-entry handshake with passes remaining, `pc` wraps to 0 and `instruction=mem[0]` is loaded in the same cycle. No bubble occurs and `done` is not pulsed.
  - `done` pulses once, after the final pass.
  - `len==0` goes straight to DONE regardless of `loop_cnt`.
- When undefined: the port is absent and exactly one pass runs.

## Structure
- Shared package `vp_pkg`:
  - `IW`.
  - Opcode enum: `OP_LOAD=2'b00`, `OP_STORE=2'b01`, `OP_ADD=2'b10`, `OP_MUL=2'b11`.
  - Field bit-position constants.
  - Sequencer state typedef.
- Sub-module `vp_instr_mem`: DEPTH x IW RAM with synchronous write port and asynchronous read port.
- FSM, `pc`, `len` and loop counter live in the top of this block.

## Test plan
- Write 4 entries (13'h0001, 13'h0200, 13'h0511, 13'h0621), `prog_len=4`, `start`, `instr_ready=1` -> `instr_valid` for 4 consecutive cycles presenting exactly that sequence with `pc` 0..3; `done` 1 cycle after the last entry.
- Same program, `instr_ready` low on the 2nd valid cycle for 3 cycles -> 13'h0200 held stable with `pc=1`; the sequence resumes intact; `done` comes 3 cycles later than in the first scenario.
- `prog_len=0`, `start` -> no `instr_valid`, `done` the next cycle. `prog_len=DEPTH+1` -> exactly DEPTH instructions issued.
- Reset asserted at `pc=2` -> next cycle IDLE, `instr_valid=0`, no `done`. Re-`start` reissues from 13'h0001, confirming memory was retained.
- `prog_we` to entry 0 with 13'h1000 while busy -> ignored; the next run still issues 13'h0001 first. `start` while busy -> ignored.
- With `VP_SEQ_LOOP_EN`, `prog_len=2`, `loop_cnt=2` -> 6 back-to-back instructions (A,B,A,B,A,B) and a single `done`.
